// File: rtl/cnt_expand_if.sv
// Count-in / beat-out stream bundle for cnt_expand. The Y_sat line exists only
// when CNT_EXPAND_SAT_EN is defined.
interface cnt_expand_if #(
  parameter int depth = 18,
  parameter int width = 4
);
  localparam int N  = $clog2(depth + 1);
  localparam int CW = $clog2(width + 1);

  logic          S_valid;
  logic          S_ready;
  logic [N-1:0]  S;
  logic          Y_valid;
  logic          Y_ready;
  logic [width-1:0] Y;
  logic          Y_last;
  logic [CW-1:0] Y_cnt;
`ifdef CNT_EXPAND_SAT_EN
  logic          Y_sat;

  modport slave (
    input  S_valid, S, Y_ready,
    output S_ready, Y_valid, Y, Y_last, Y_cnt, Y_sat
  );
  modport master (
    output S_valid, S, Y_ready,
    input  S_ready, Y_valid, Y, Y_last, Y_cnt, Y_sat
  );
`else
  modport slave (
    input  S_valid, S, Y_ready,
    output S_ready, Y_valid, Y, Y_last, Y_cnt
  );
  modport master (
    output S_valid, S, Y_ready,
    input  S_ready, Y_valid, Y, Y_last, Y_cnt
  );
`endif
endinterface

// File: rtl/cnt_expand.sv
// Thermometer expander: turns a bit count into a depth-bit LSB-packed mask sent
// as width-bit beats. Optional CNT_EXPAND_SAT_EN adds the Y_sat overflow flag.
module cnt_expand #(
  parameter int depth = 18,
  parameter int width = 4
) (
  input  logic          clk,
  input  logic          rst,
  cnt_expand_if.slave   bus
);
  localparam int N     = $clog2(depth + 1);
  localparam int CW    = $clog2(width + 1);
  localparam int BEATS = (depth + width - 1) / width;
  localparam int KW    = $clog2(BEATS + 1);
  localparam logic [N-1:0]  DEPTH_N = N'(depth);
  localparam logic [KW-1:0] LAST_K  = KW'(BEATS - 1);

  function automatic logic [N-1:0] clamp_cnt(input logic [N-1:0] s);
    return (s > DEPTH_N) ? DEPTH_N : s;
  endfunction

  typedef enum logic {IDLE, EMIT} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  c_q, c_d;
  logic [KW-1:0] k_q, k_d;
`ifdef CNT_EXPAND_SAT_EN
  logic          sat_q, sat_d;
`endif

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    k_d     = k_q;
`ifdef CNT_EXPAND_SAT_EN
    sat_d   = sat_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.S_valid) begin
          state_d = EMIT;
          c_d     = clamp_cnt(bus.S);
          k_d     = '0;
`ifdef CNT_EXPAND_SAT_EN
          sat_d   = (bus.S > DEPTH_N);
`endif
        end
      end
      EMIT: begin
        if (bus.Y_ready) begin
          if (k_q == LAST_K) state_d = IDLE;
          else               k_d     = k_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      c_q     <= '0;
      k_q     <= '0;
`ifdef CNT_EXPAND_SAT_EN
      sat_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      k_q     <= k_d;
`ifdef CNT_EXPAND_SAT_EN
      sat_q   <= sat_d;
`endif
    end
  end

  // Beat decode from C and K; bits past depth stay 0 because C never exceeds depth.
  logic             y_valid;
  logic [width-1:0] y_beat;
  int               base;
  int               rem;

  always_comb begin
    y_valid = (state_q == EMIT) && !rst;
    base    = int'(k_q) * width;
    y_beat  = '0;
    for (int i = 0; i < width; i++) begin
      y_beat[i] = ((base + i) < int'(c_q));
    end
    rem = int'(c_q) - base;
    if (rem < 0)     rem = 0;
    if (rem > width) rem = width;

    bus.S_ready = (state_q == IDLE) && !rst;
    bus.Y_valid = y_valid;
    bus.Y       = y_valid ? y_beat : '0;
    bus.Y_last  = y_valid && (k_q == LAST_K);
    bus.Y_cnt   = y_valid ? CW'(rem) : '0;
`ifdef CNT_EXPAND_SAT_EN
    bus.Y_sat   = y_valid && sat_q;
`endif
  end
endmodule

// File: doc/cnt_expand.md
# cnt_expand

Unary (thermometer) expander: the decode direction of the bit counter. It accepts a bit count `S` and regenerates a `depth`-bit vector holding exactly `S` ones, packed LSB-first. The vector leaves as a stream of `width`-bit beats with valid/ready handshakes on both sides. It sits downstream of counter/compressor datapaths, where a population value must be turned back into a mask (lane enables, partial-product masks).

## Interface
Parameters:
- `depth`, 18: length of the regenerated vector; legal for depth > 1.
- `width`, 4: beat width; 1 ≤ width ≤ depth.
- Derived: `beats` = ceil(depth/width); count width `n` = log2floor(depth)+1.

Ports:
- `clk`  in  1  clock. One clock domain; all state updates on the rising edge.
- `rst`  in  1  reset. Synchronous and active-high.
- `S_valid`  in  1  count valid.
- `S_ready`  out  1  count accepted when `S_valid` && `S_ready`.
- `S`  in  n  count value.
- `Y_valid`  out  1  beat valid.
- `Y_ready`  in  1  beat consumed when `Y_valid` && `Y_ready`.
- `Y`  out  width  current beat.
- `Y_last`  out  1  current beat is the final beat (index beats-1).
- `Y_cnt`  out  log2floor(width)+1  number of ones in `Y`.
- `Y_sat`  out  1  only present with `CNT_EXPAND_SAT_EN` (see Configuration).

## Operation
- Thermometer word T (depth bits): T[j] = 1 iff j < min(S, depth).
- Beat k carries T[k*width + width-1 : k*width]. Bit positions ≥ depth in the final beat read 0.
- FSM, two states:
  - IDLE: `S_ready`=1, `Y_valid`=0. On an accept, latch the clamped count into register C, set beat index K=0, go to EMIT.
  - EMIT: `S_ready`=0, `Y_valid`=1, `Y` = beat K of T(C).
    - On a beat handshake with K < beats-1: K ← K+1.
    - On a beat handshake with K = beats-1: go to IDLE.
- `Y`, `Y_last` and `Y_cnt` are combinational decodes of the registers C and K only. No input reaches them combinationally.
- `Y_cnt` = clamp(C − K*width, 0, width'), where width' is the number of valid bit positions in beat K.
- Counts above depth are clamped to depth. The clamp is a compare and mux on `S` at accept time.
- Output values while `Y_valid`=0: `Y`=0, `Y_cnt`=0, `Y_last`=0.

## Timing
- Reset: while `rst`=1, the state is forced to IDLE and C, K are cleared. `S_ready`=0 and `Y_valid`=0 during reset. From the first cycle after `rst` deasserts: `S_ready`=1, `Y_valid`=0, `Y`=0, `Y_last`=0, `Y_cnt`=0.
- Latency: an accept in cycle t presents beat 0 in cycle t+1.
- A transfer occupies exactly `beats` cycles when `Y_ready` is held high.
- After the last-beat handshake, the block spends one cycle in IDLE before the next beat 0 can appear. With continuous input and output, a new transfer starts every beats+1 cycles.
- Backpressure: while `Y_valid`=1 and `Y_ready`=0, `Y`, `Y_last`, `Y_cnt` and `Y_sat` stay stable. `Y_valid` never drops without a handshake.
- `S` is sampled only in the accept cycle. `S_valid` asserted outside IDLE has no effect.
- Reset mid-transfer: the transfer is aborted and no further beats are emitted. The block returns to IDLE in the cycle after reset is released.
- S=0 still produces `beats` all-zero beats; `Y_last` is set on the final one.

## Configuration
- `CNT_EXPAND_SAT_EN` defined:
  - Adds port `Y_sat` (out, 1) and a 1-bit register.
  - `Y_sat`=1 for every beat of a transfer whose raw `S` exceeded depth, and 0 otherwise.
  - `Y_sat` reset value is 0.
- `CNT_EXPAND_SAT_EN` not defined:
  - Port and register are absent.
  - Clamping is still applied, so beat data is identical in both builds.

## Test plan
Defaults used throughout: depth=18, width=4, so beats=5 and n=5.
- Reset release, idle: → `S_ready`=1, `Y_valid`=0, `Y`=0.
- S=7, `Y_ready`=1:
  - `Y` = 4'b1111, 4'b0111, 4'b0000, 4'b0000, 4'b0000 on consecutive cycles.
  - `Y_cnt` = 4, 3, 0, 0, 0.
  - `Y_last` only on beat 4.
  - First beat one cycle after the accept.
- S=18 → beats 1111, 1111, 1111, 1111, 0011; `Y_cnt` on the last beat = 2. S=31 → identical beats; with the macro defined, `Y_sat`=1 on all 5 beats.
- S=0 → five beats of 0000 with `Y_last` on the fifth. Back-to-back `S_valid`: the next beat 0 appears exactly 6 cycles after the previous beat 0.
- S=9, `Y_ready` low for 3 cycles while beat 2 is presented → `Y` holds 4'b0001, `Y_valid` stays 1, K does not advance. Stream resumes with 0000, 0000.
- S=12, `rst` pulsed for one cycle during beat 2 → next cycle `Y_valid`=0. After release `S_ready`=1, and a new S=1 yields 0001, 0000, 0000, 0000, 0000.
